// File: rtl/pong_pkg.sv
// Shared Pong constants and the paddle motion FSM state encoding.
package pong_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int PADDLE_H   = 64;
    localparam int PADDLE_Y_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_APPLY = 2'd2,
        ST_CLAMP = 2'd3
    } paddle_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for slow level signals crossing into the local clock.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First stage may go metastable; second stage gives a settled copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= {WIDTH{1'b0}};
            r_sync <= {WIDTH{1'b0}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/paddle_motion_ctrl.sv
// Turns decoded mouse packets into a clamped absolute paddle Y, applied once per frame.
module paddle_motion_ctrl
    import pong_pkg::*;
#(
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = pong_pkg::SCREEN_H,
    parameter int PADDLE_H     = pong_pkg::PADDLE_H,
    parameter int Y_RESET      = 208,
    parameter int SPEED_SHIFT  = 1,
    parameter int STALE_FRAMES = 60
) (
    input  logic                  clk_25MHz,
    input  logic                  reset_n,
    input  logic                  paddle_dir,
    input  logic [7:0]            paddle_speed,
    input  logic                  new_output_flag,
    input  logic                  error_flag,
    input  logic                  frame_tick,
    output logic [PADDLE_Y_W-1:0] paddle_y,
    output logic                  y_update,
    output logic                  mouse_active,
    output logic                  pkt_dropped
);

    localparam int Y_TOP   = Y_MAX - PADDLE_H;
    localparam int STALE_W = $clog2(STALE_FRAMES + 1);

    localparam logic signed [12:0]  C_SUM_LO  = 13'(Y_MIN);
    localparam logic signed [12:0]  C_SUM_HI  = 13'(Y_TOP);
    localparam logic [STALE_W-1:0]  C_STALE   = STALE_W'(STALE_FRAMES);

    // Elaboration-time sanity of the geometry parameters.
    if ((Y_RESET < Y_MIN) || (Y_RESET > Y_TOP)) begin : g_bad_reset
        $error("paddle_motion_ctrl: Y_RESET outside [Y_MIN, Y_MAX-PADDLE_H]");
    end
    if (Y_TOP >= 1024) begin : g_bad_range
        $error("paddle_motion_ctrl: Y_MAX-PADDLE_H does not fit in 10 bits");
    end

    // Registers
    paddle_state_e          r_state;
    logic signed [11:0]     r_acc;
    logic signed [11:0]     r_snap;
    logic signed [12:0]     r_sum;
    logic [PADDLE_Y_W-1:0]  r_paddle_y;
    logic                   r_y_update;
    logic                   r_mouse_active;
    logic                   r_pkt_dropped;
    logic [STALE_W-1:0]     r_stale_cnt;
    logic                   r_pkt_since;

    // Combinational nets
    paddle_state_e          w_state_nxt;
    logic                   w_err_s;
    logic                   w_accept;
    logic                   w_drop;
    logic                   w_snap;
    logic [10:0]            w_delta;
    logic signed [11:0]     w_acc_base;
    logic signed [12:0]     w_acc_ext;
    logic signed [12:0]     w_delta_ext;
    logic signed [12:0]     w_acc_sum;
    logic signed [11:0]     w_acc_sat;
    logic signed [11:0]     w_acc_nxt;
    logic signed [12:0]     w_apply_sum;
    logic [PADDLE_Y_W-1:0]  w_clamped;
    logic [STALE_W-1:0]     w_stale_nxt;
    logic                   w_active_nxt;
    logic                   w_since_nxt;

    sync_2ff #(
        .WIDTH (1)
    ) u_err_sync (
        .clk   (clk_25MHz),
        .rst_n (reset_n),
        .i_d   (error_flag),
        .o_q   (w_err_s)
    );

    assign w_accept = new_output_flag & ~w_err_s;
    assign w_drop   = new_output_flag &  w_err_s;
    // Snapshot only from ACCUM; IDLE already holds a zero accumulator.
    assign w_snap   = frame_tick & (r_state == ST_ACCUM);
    assign w_delta  = {3'b000, paddle_speed} >> SPEED_SHIFT;

    // Saturating signed accumulation of the packet delta (a snapshot clears first).
    always_comb begin
        w_acc_base  = w_snap ? 12'sd0 : r_acc;
        w_acc_ext   = {w_acc_base[11], w_acc_base};
        w_delta_ext = $signed({2'b00, w_delta});
        if (paddle_dir) begin
            w_acc_sum = w_acc_ext + w_delta_ext;
        end else begin
            w_acc_sum = w_acc_ext - w_delta_ext;
        end
        if (w_acc_sum > 13'sd2047) begin
            w_acc_sat = 12'sh7FF;
        end else if (w_acc_sum < -13'sd2048) begin
            w_acc_sat = 12'sh800;
        end else begin
            w_acc_sat = w_acc_sum[11:0];
        end
        if (w_accept) begin
            w_acc_nxt = w_acc_sat;
        end else begin
            w_acc_nxt = w_acc_base;
        end
    end

    // Candidate position and its clamp into the legal paddle range.
    always_comb begin
        w_apply_sum = $signed({3'b000, r_paddle_y}) + {r_snap[11], r_snap};
        if (r_sum < C_SUM_LO) begin
            w_clamped = PADDLE_Y_W'(Y_MIN);
        end else if (r_sum > C_SUM_HI) begin
            w_clamped = PADDLE_Y_W'(Y_TOP);
        end else begin
            w_clamped = r_sum[PADDLE_Y_W-1:0];
        end
    end

    // Staleness tracking: count silent frames, any accepted packet revives the mouse.
    always_comb begin
        w_stale_nxt  = r_stale_cnt;
        w_since_nxt  = r_pkt_since;
        w_active_nxt = r_mouse_active;
        if (w_accept) begin
            w_stale_nxt = {STALE_W{1'b0}};
            w_since_nxt = 1'b1;
        end else if (frame_tick) begin
            w_since_nxt = 1'b0;
            if (!r_pkt_since && (r_stale_cnt != C_STALE)) begin
                w_stale_nxt = r_stale_cnt + STALE_W'(1);
            end else begin
                w_stale_nxt = r_stale_cnt;
            end
        end else begin
            w_stale_nxt = r_stale_cnt;
        end
        if (w_accept) begin
            w_active_nxt = 1'b1;
        end else if (w_stale_nxt == C_STALE) begin
            w_active_nxt = 1'b0;
        end else begin
            w_active_nxt = r_mouse_active;
        end
    end

    // Next-state logic of the per-frame apply sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (frame_tick) begin
                    w_state_nxt = ST_APPLY;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_APPLY: begin
                w_state_nxt = ST_CLAMP;
            end
            ST_CLAMP: begin
                if ((w_acc_nxt != 12'sd0) || w_accept) begin
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, accumulator, position and status registers.
    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_acc          <= 12'sd0;
            r_snap         <= 12'sd0;
            r_sum          <= 13'sd0;
            r_paddle_y     <= PADDLE_Y_W'(Y_RESET);
            r_y_update     <= 1'b0;
            r_mouse_active <= 1'b0;
            r_pkt_dropped  <= 1'b0;
            r_stale_cnt    <= {STALE_W{1'b0}};
            r_pkt_since    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_acc          <= w_acc_nxt;
            r_pkt_dropped  <= w_drop;
            r_stale_cnt    <= w_stale_nxt;
            r_pkt_since    <= w_since_nxt;
            r_mouse_active <= w_active_nxt;
            if (w_snap) begin
                r_snap <= r_acc;
            end else begin
                r_snap <= r_snap;
            end
            if (r_state == ST_APPLY) begin
                r_sum <= w_apply_sum;
            end else begin
                r_sum <= r_sum;
            end
            if (r_state == ST_CLAMP) begin
                r_paddle_y <= w_clamped;
                r_y_update <= (w_clamped != r_paddle_y);
            end else begin
                r_paddle_y <= r_paddle_y;
                r_y_update <= 1'b0;
            end
        end
    end

    assign paddle_y     = r_paddle_y;
    assign y_update     = r_y_update;
    assign mouse_active = r_mouse_active;
    assign pkt_dropped  = r_pkt_dropped;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Directed plus randomised bench for paddle_motion_ctrl against a frame-level model.
module tb_paddle_motion_ctrl;

    logic       clk_25MHz = 1'b0;
    logic       reset_n   = 1'b0;
    logic       paddle_dir = 1'b0;
    logic [7:0] paddle_speed = 8'd0;
    logic       new_output_flag = 1'b0;
    logic       error_flag = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] paddle_y;
    logic       y_update;
    logic       mouse_active;
    logic       pkt_dropped;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state (spec constants: shift 1, top limit 480-64, stale 60)
    int m_y = 208;
    int m_acc = 0;
    int m_snap = 0;
    int m_cd = 0;
    int m_stale = 0;
    bit m_since = 1'b0;
    bit m_active = 1'b0;
    bit e_upd = 1'b0;
    bit e_drop = 1'b0;

    paddle_motion_ctrl dut (
        .clk_25MHz       (clk_25MHz),
        .reset_n         (reset_n),
        .paddle_dir      (paddle_dir),
        .paddle_speed    (paddle_speed),
        .new_output_flag (new_output_flag),
        .error_flag      (error_flag),
        .frame_tick      (frame_tick),
        .paddle_y        (paddle_y),
        .y_update        (y_update),
        .mouse_active    (mouse_active),
        .pkt_dropped     (pkt_dropped)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame-level model of one clock edge; error_flag is held stable around packets.
    task automatic model_edge(input bit tick, input bit nof, input bit dir, input int spd);
        int nv;
        int d;
        bit acc_ok;
        e_upd = 1'b0;
        if (m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) begin
                nv = m_y + m_snap;
                if (nv < 0) nv = 0;
                if (nv > 480 - 64) nv = 480 - 64;
                e_upd = (nv != m_y);
                m_y = nv;
            end
        end
        acc_ok = nof && !error_flag;
        e_drop = nof && error_flag;
        if (tick) begin
            if (!m_since && !acc_ok && m_stale < 60) m_stale++;
            m_since = 1'b0;
            if (m_cd == 0) begin
                m_snap = m_acc;
                m_acc  = 0;
                m_cd   = 2;
            end
        end
        if (acc_ok) begin
            d = spd / 2;
            m_acc = dir ? m_acc + d : m_acc - d;
            if (m_acc > 2047) m_acc = 2047;
            if (m_acc < -2048) m_acc = -2048;
            m_stale  = 0;
            m_since  = 1'b1;
            m_active = 1'b1;
        end else if (m_stale == 60) begin
            m_active = 1'b0;
        end
    endtask

    task automatic step(input bit tick, input bit nof, input bit dir, input int spd);
        frame_tick      = tick;
        new_output_flag = nof;
        paddle_dir      = dir;
        paddle_speed    = spd[7:0];
        @(posedge clk_25MHz);
        model_edge(tick, nof, dir, spd);
        #1;
        frame_tick      = 1'b0;
        new_output_flag = 1'b0;
        chk("paddle_y", int'(paddle_y), m_y);
        chk("y_update", int'(y_update), int'(e_upd));
        chk("mouse_active", int'(mouse_active), int'(m_active));
        chk("pkt_dropped", int'(pkt_dropped), int'(e_drop));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk_25MHz);
        #1;
        chk("rst_y", int'(paddle_y), 208);
        chk("rst_upd", int'(y_update), 0);
        chk("rst_active", int'(mouse_active), 0);
        chk("rst_drop", int'(pkt_dropped), 0);
        @(negedge clk_25MHz);
        reset_n = 1'b1;

        // No packets, three frames: nothing moves
        idle(3);
        for (int f = 0; f < 3; f++) begin
            step(1'b1, 1'b0, 1'b0, 0);
            idle(4);
        end
        chk("t1_y", int'(paddle_y), 208);
        chk("t1_active", int'(mouse_active), 0);

        // Two downward packets: 20>>1 + 10>>1 = 15 -> 223 two edges after the tick
        step(1'b0, 1'b1, 1'b1, 20);
        idle(1);
        step(1'b0, 1'b1, 1'b1, 10);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 0);
        idle(2);
        chk("t2_y", int'(paddle_y), 223);
        chk("t2_upd", int'(y_update), 1);
        chk("t2_active", int'(mouse_active), 1);
        idle(3);

        // Move to 10 (-127 - 86), then clamp at the top, then repeat without change
        step(1'b0, 1'b1, 1'b0, 255);
        step(1'b0, 1'b1, 1'b0, 172);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 0);
        idle(2);
        chk("t3_y10", int'(paddle_y), 10);
        idle(2);
        for (int r = 0; r < 2; r++) begin
            step(1'b0, 1'b1, 1'b0, 255);
            step(1'b1, 1'b0, 1'b0, 0);
            idle(2);
            chk("t3_y0", int'(paddle_y), 0);
            chk("t3_upd", int'(y_update), (r == 0) ? 1 : 0);
            idle(2);
        end

        // Saturating accumulation, clamped at the bottom limit
        for (int p = 0; p < 20; p++) step(1'b0, 1'b1, 1'b1, 255);
        step(1'b1, 1'b0, 1'b0, 0);
        idle(2);
        chk("t4_y416", int'(paddle_y), 416);
        idle(2);

        // Packet coincident with frame_tick counts toward the next frame
        step(1'b0, 1'b1, 1'b0, 200);
        step(1'b1, 1'b0, 1'b0, 0);
        idle(2);
        chk("t5_y316", int'(paddle_y), 316);
        idle(2);
        step(1'b1, 1'b1, 1'b1, 8);
        idle(2);
        chk("t5_hold", int'(paddle_y), 316);
        chk("t5_noupd", int'(y_update), 0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 0);
        idle(2);
        chk("t5_y320", int'(paddle_y), 320);
        idle(2);

        // Dropped packet under error, then 60 silent frames
        error_flag = 1'b1;
        idle(3);
        step(1'b0, 1'b1, 1'b1, 100);
        chk("t6_drop", int'(pkt_dropped), 1);
        idle(1);
        error_flag = 1'b0;
        idle(3);
        for (int f = 1; f <= 60; f++) begin
            step(1'b1, 1'b0, 1'b0, 0);
            idle(3);
            if (f == 59) chk("t6_active59", int'(mouse_active), 1);
            if (f == 60) chk("t6_active60", int'(mouse_active), 0);
        end
        chk("t6_y", int'(paddle_y), 320);

        // Randomised frames
        for (int f = 0; f < 40; f++) begin
            error_flag = ($urandom_range(0, 4) == 0);
            idle(3);
            for (int k = 0; k < int'($urandom_range(2, 10)); k++) begin
                step(1'b0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 255)));
            end
            step(1'b1, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)));
            idle(3);
        end
        error_flag = 1'b0;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
